// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter.
// Sends one command byte to the device over open-drain PS2C/PS2D.
// The host only inhibits and requests; the device generates all bus clocks.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned FILTER_LEN     = 4
) (
    input  logic       clkB,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe
);

    localparam int unsigned MAX_CYC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CW      = $clog2(MAX_CYC + 1);
    localparam int unsigned FW      = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INHIBIT   = 3'd1;
    localparam logic [2:0] S_RTS       = 3'd2;
    localparam logic [2:0] S_WAIT_EDGE = 3'd3;
    localparam logic [2:0] S_ACK       = 3'd4;
    localparam logic [2:0] S_RELEASE   = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;

    // Index 0 is PS2C, index 1 is PS2D.
    logic [1:0]    meta_q;
    logic [1:0]    sync_q;
    logic [1:0]    filt_q;
    logic [FW-1:0] flt_cnt_q [2];
    logic          c_filt_d1_q;
    logic          fall_c;

    logic [2:0]    state_q, state_n;
    logic [CW-1:0] cyc_q, cyc_n;
    logic [3:0]    edge_q, edge_n;
    logic [9:0]    frame_q, frame_n;
    logic          ack_ok_q, ack_ok_n;
    logic          c_oe_n, d_oe_n, busy_n, done_n, err_n;
    logic [15:0]   frame_ext_c;

    // Two-flop synchronizers; idle bus level is high.
    always_ff @(posedge clkB or posedge rst) begin
        if (rst) begin
            meta_q <= 2'b11;
            sync_q <= 2'b11;
        end else begin
            meta_q <= {ps2d_in, ps2c_in};
            sync_q <= meta_q;
        end
    end

    // Accept a new level only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clkB or posedge rst) begin
        if (rst) begin
            filt_q      <= 2'b11;
            c_filt_d1_q <= 1'b1;
            for (int i = 0; i < 2; i++) flt_cnt_q[i] <= '0;
        end else begin
            c_filt_d1_q <= filt_q[0];
            for (int i = 0; i < 2; i++) begin
                if (sync_q[i] == filt_q[i]) begin
                    flt_cnt_q[i] <= '0;
                end else if (flt_cnt_q[i] == FW'(FILTER_LEN - 1)) begin
                    filt_q[i]    <= sync_q[i];
                    flt_cnt_q[i] <= '0;
                end else begin
                    flt_cnt_q[i] <= flt_cnt_q[i] + FW'(1);
                end
            end
        end
    end

    assign fall_c      = c_filt_d1_q & ~filt_q[0];
    assign frame_ext_c = {6'b111111, frame_q};

    // State, datapath and registered outputs.
    always_ff @(posedge clkB or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cyc_q    <= '0;
            edge_q   <= '0;
            frame_q  <= '0;
            ack_ok_q <= 1'b0;
            ps2c_oe  <= 1'b0;
            ps2d_oe  <= 1'b0;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            tx_err   <= 1'b0;
        end else begin
            state_q  <= state_n;
            cyc_q    <= cyc_n;
            edge_q   <= edge_n;
            frame_q  <= frame_n;
            ack_ok_q <= ack_ok_n;
            ps2c_oe  <= c_oe_n;
            ps2d_oe  <= d_oe_n;
            tx_busy  <= busy_n;
            tx_done  <= done_n;
            tx_err   <= err_n;
        end
    end

    // Next state plus next values of every registered output.
    always_comb begin
        state_n  = state_q;
        cyc_n    = cyc_q;
        edge_n   = edge_q;
        frame_n  = frame_q;
        ack_ok_n = ack_ok_q;
        c_oe_n   = 1'b0;
        d_oe_n   = ps2d_oe;
        busy_n   = tx_busy;
        done_n   = 1'b0;
        err_n    = 1'b0;
        case (state_q)
            S_IDLE: begin
                d_oe_n = 1'b0;
                busy_n = 1'b0;
                if (tx_start) begin
                    frame_n = {1'b1, ~^tx_data, tx_data};
                    cyc_n   = '0;
                    c_oe_n  = 1'b1;
                    busy_n  = 1'b1;
                    state_n = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                c_oe_n = 1'b1;
                if (cyc_q == CW'(INHIBIT_CYCLES - 1)) begin
                    cyc_n   = '0;
                    d_oe_n  = 1'b1;
                    state_n = S_RTS;
                end else begin
                    cyc_n = cyc_q + CW'(1);
                end
            end
            S_RTS: begin
                // Start bit stays driven low until the device's first falling edge.
                d_oe_n  = 1'b1;
                cyc_n   = '0;
                edge_n  = '0;
                state_n = S_WAIT_EDGE;
            end
            S_WAIT_EDGE, S_ACK, S_RELEASE: begin
                if (cyc_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    d_oe_n   = 1'b0;
                    ack_ok_n = 1'b0;
                    done_n   = 1'b1;
                    err_n    = 1'b1;
                    busy_n   = 1'b0;
                    state_n  = S_DONE;
                end else begin
                    cyc_n = cyc_q + CW'(1);
                    case (state_q)
                        S_WAIT_EDGE: begin
                            if (fall_c) begin
                                edge_n = edge_q + 4'd1;
                                if (edge_q == 4'd10) begin
                                    d_oe_n  = 1'b0;
                                    state_n = S_ACK;
                                end else begin
                                    d_oe_n = ~frame_ext_c[edge_q];
                                end
                            end
                        end
                        S_ACK: begin
                            ack_ok_n = ~filt_q[1];
                            state_n  = S_RELEASE;
                        end
                        S_RELEASE: begin
                            if (filt_q[0] & filt_q[1]) begin
                                done_n  = 1'b1;
                                err_n   = ~ack_ok_q;
                                busy_n  = 1'b0;
                                state_n = S_DONE;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
            S_DONE: begin
                d_oe_n  = 1'b0;
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end
            default: begin
                d_oe_n  = 1'b0;
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: PS/2 device model driving ps2_host_tx, with a frame reference model.
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int TMO  = 3000;
    localparam int FLT  = 2;
    localparam int HALF = 40;

    logic       clkB = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_busy, tx_done, tx_err;
    logic       ps2c_in, ps2d_in, ps2c_oe, ps2d_oe;
    logic       dev_c_low = 1'b0;
    logic       dev_d_low = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic       done_err = 1'b0;
    logic       done_busy = 1'b0;
    logic [1:0] done_oe = 2'b00;
    logic [1:0] done_lines = 2'b00;

    logic [10:0] dev_bits;
    bit          dev_busy_drop;
    int          inh_c, inh_cd, exit_cyc, xfer_n0;
    bit          start_held, done_ok;

    always #5 clkB = ~clkB;

    // Open-drain bus: a line is low if either side pulls it.
    assign ps2c_in = ~(ps2c_oe | dev_c_low);
    assign ps2d_in = ~(ps2d_oe | dev_d_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .FILTER_LEN    (FLT)
    ) dut (
        .clkB    (clkB),
        .rst     (rst),
        .tx_data (tx_data),
        .tx_start(tx_start),
        .tx_busy (tx_busy),
        .tx_done (tx_done),
        .tx_err  (tx_err),
        .ps2c_in (ps2c_in),
        .ps2d_in (ps2d_in),
        .ps2c_oe (ps2c_oe),
        .ps2d_oe (ps2d_oe)
    );

    always @(posedge clkB) cyc <= cyc + 1;

    // Record every completion pulse.
    always @(negedge clkB) begin
        if (tx_done === 1'b1) begin
            done_cnt   <= done_cnt + 1;
            done_cyc   <= cyc;
            done_err   <= tx_err;
            done_busy  <= tx_busy;
            done_oe    <= {ps2c_oe, ps2d_oe};
            done_lines <= {ps2c_in, ps2d_in};
        end
    end

    // Expected 11-bit frame as seen on PS2D: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] ref_frame(input logic [7:0] d);
        int ones;
        logic [10:0] f;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        f[9]  = ((ones % 2) == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic start_tx(input logic [7:0] d);
        @(negedge clkB);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clkB);
        tx_start = 1'b0;
    endtask

    // Measure the inhibit/request window; stops at the first cycle with PS2C released.
    task automatic host_phase();
        int n;
        n = 0;
        inh_c = 0;
        inh_cd = 0;
        while (ps2c_oe === 1'b1 && n < 1000) begin
            if (ps2d_oe === 1'b1) inh_cd++;
            else inh_c++;
            n++;
            @(negedge clkB);
        end
        start_held = (ps2d_oe === 1'b1);
        exit_cyc   = cyc;
    endtask

    // Device: reads start bit, clocks nfalls edges, samples data on the rising edge.
    task automatic device_clock(input bit ack, input int nfalls, input int glitch_after);
        dev_busy_drop = 1'b0;
        dev_bits = '1;
        repeat (20) begin
            @(negedge clkB);
            if (tx_busy !== 1'b1) dev_busy_drop = 1'b1;
        end
        dev_bits[0] = ps2d_in;
        for (int i = 1; i <= nfalls; i++) begin
            if (i == 11 && ack) dev_d_low = 1'b1;
            dev_c_low = 1'b1;
            repeat (HALF) begin
                @(negedge clkB);
                if (tx_busy !== 1'b1) dev_busy_drop = 1'b1;
            end
            if (i == nfalls && nfalls < 11) return;
            if (i <= 10) dev_bits[i] = ps2d_in;
            dev_c_low = 1'b0;
            if (i == glitch_after) begin
                repeat (15) @(negedge clkB);
                dev_c_low = 1'b1;
                @(negedge clkB);
                dev_c_low = 1'b0;
                repeat (HALF - 16) @(negedge clkB);
            end else if (i < 11) begin
                repeat (HALF) @(negedge clkB);
            end
        end
        repeat (5) @(negedge clkB);
        dev_d_low = 1'b0;
    endtask

    task automatic wait_done(input int n0, input int limit);
        int t;
        t = 0;
        while (done_cnt == n0 && t < limit) begin
            @(negedge clkB);
            t++;
        end
        done_ok = (done_cnt != n0);
    endtask

    task automatic do_transfer(input logic [7:0] d, input bit ack, input int glitch_after, input bit extra_start);
        xfer_n0 = done_cnt;
        start_tx(d);
        host_phase();
        if (extra_start) begin
            tx_data  = 8'h55;
            tx_start = 1'b1;
            @(negedge clkB);
            tx_start = 1'b0;
        end
        device_clock(ack, 11, glitch_after);
        wait_done(xfer_n0, 300);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clkB);
        checks++;
        if ({tx_busy, tx_done, tx_err, ps2c_oe, ps2d_oe} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 00000", {tx_busy, tx_done, tx_err, ps2c_oe, ps2d_oe});
        end
        rst = 1'b0;
        repeat (5) @(negedge clkB);
        checks++;
        if ({tx_busy, tx_done, tx_err, ps2c_oe, ps2d_oe} !== 5'b0) begin
            errors++;
            $display("FAIL idle_after_reset got %b want 00000", {tx_busy, tx_done, tx_err, ps2c_oe, ps2d_oe});
        end
    endtask

    task automatic test_led_cmd();
        logic [10:0] exp;
        exp = ref_frame(8'hED);
        do_transfer(8'hED, 1'b1, 0, 1'b0);
        checks++;
        if (inh_c != INH || inh_cd != 1) begin
            errors++;
            $display("FAIL inhibit_len got c=%0d cd=%0d want c=%0d cd=1", inh_c, inh_cd, INH);
        end
        checks++;
        if (!start_held) begin
            errors++;
            $display("FAIL start_bit got ps2d_oe=%b want 1", ps2d_oe);
        end
        checks++;
        if (dev_bits !== exp) begin
            errors++;
            $display("FAIL frame_ED got %b want %b", dev_bits, exp);
        end
        checks++;
        if (dev_busy_drop) begin
            errors++;
            $display("FAIL busy_during_ED got drop=1 want 0");
        end
        checks++;
        if (!done_ok || done_err !== 1'b0 || done_busy !== 1'b0 || done_oe !== 2'b00) begin
            errors++;
            $display("FAIL done_ED got ok=%b err=%b busy=%b oe=%b want 1 0 0 00", done_ok, done_err, done_busy, done_oe);
        end
    endtask

    task automatic test_parity();
        logic [7:0]  vals [2];
        logic [10:0] exp;
        vals[0] = 8'h00;
        vals[1] = 8'h01;
        for (int k = 0; k < 2; k++) begin
            exp = ref_frame(vals[k]);
            do_transfer(vals[k], 1'b1, 0, 1'b0);
            checks++;
            if (dev_bits[9] !== exp[9]) begin
                errors++;
                $display("FAIL parity_%02h got %b want %b", vals[k], dev_bits[9], exp[9]);
            end
            checks++;
            if (!done_ok || done_err !== 1'b0) begin
                errors++;
                $display("FAIL err_%02h got ok=%b err=%b want 1 0", vals[k], done_ok, done_err);
            end
        end
    endtask

    task automatic test_timeout();
        int n0;
        n0 = done_cnt;
        start_tx(8'h3C);
        host_phase();
        wait_done(n0, TMO + 200);
        checks++;
        if (!done_ok || (done_cyc - exit_cyc) != TMO) begin
            errors++;
            $display("FAIL timeout_time got ok=%b dt=%0d want 1 %0d", done_ok, done_cyc - exit_cyc, TMO);
        end
        checks++;
        if (done_err !== 1'b1 || done_oe !== 2'b00) begin
            errors++;
            $display("FAIL timeout_err got err=%b oe=%b want 1 00", done_err, done_oe);
        end
    endtask

    task automatic test_no_ack();
        logic [10:0] exp;
        exp = ref_frame(8'hA7);
        do_transfer(8'hA7, 1'b0, 0, 1'b0);
        checks++;
        if (!done_ok || done_err !== 1'b1 || done_lines !== 2'b11) begin
            errors++;
            $display("FAIL no_ack got ok=%b err=%b lines=%b want 1 1 11", done_ok, done_err, done_lines);
        end
        checks++;
        if (dev_bits !== exp) begin
            errors++;
            $display("FAIL frame_A7 got %b want %b", dev_bits, exp);
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        logic [10:0] exp;
        n0 = done_cnt;
        start_tx(8'hFF);
        host_phase();
        device_clock(1'b1, 5, 0);
        checks++;
        if (tx_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_at_fall5 got %b want 1", tx_busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({ps2c_oe, ps2d_oe, tx_busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid got oe/busy=%b want 000", {ps2c_oe, ps2d_oe, tx_busy});
        end
        dev_c_low = 1'b0;
        dev_d_low = 1'b0;
        @(negedge clkB);
        rst = 1'b0;
        repeat (200) @(negedge clkB);
        checks++;
        if (done_cnt != n0 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL no_done_after_reset got dones=%0d busy=%b want 0 0", done_cnt - n0, tx_busy);
        end
        exp = ref_frame(8'hFF);
        do_transfer(8'hFF, 1'b1, 0, 1'b0);
        checks++;
        if (dev_bits !== exp || !done_ok || done_err !== 1'b0) begin
            errors++;
            $display("FAIL resend_FF got bits=%b ok=%b err=%b want %b 1 0", dev_bits, done_ok, done_err, exp);
        end
    endtask

    task automatic test_busy_glitch();
        logic [10:0] exp;
        exp = ref_frame(8'hF4);
        do_transfer(8'hF4, 1'b1, 3, 1'b1);
        checks++;
        if (dev_bits !== exp || !done_ok || done_err !== 1'b0) begin
            errors++;
            $display("FAIL glitch_F4 got bits=%b ok=%b err=%b want %b 1 0", dev_bits, done_ok, done_err, exp);
        end
        repeat (100) @(negedge clkB);
        checks++;
        if (done_cnt != xfer_n0 + 1 || tx_busy !== 1'b0 || ps2c_oe !== 1'b0) begin
            errors++;
            $display("FAIL single_done got dones=%0d busy=%b c_oe=%b want 1 0 0", done_cnt - xfer_n0, tx_busy, ps2c_oe);
        end
    endtask

    task automatic test_random();
        logic [7:0]  d;
        bit          ack;
        logic [10:0] exp;
        for (int k = 0; k < 5; k++) begin
            d   = 8'($urandom_range(0, 255));
            ack = 1'($urandom_range(0, 1));
            exp = ref_frame(d);
            do_transfer(d, ack, 0, 1'b0);
            checks++;
            if (dev_bits !== exp) begin
                errors++;
                $display("FAIL rand_frame_%02h got %b want %b", d, dev_bits, exp);
            end
            checks++;
            if (!done_ok || done_err !== !ack) begin
                errors++;
                $display("FAIL rand_err_%02h got ok=%b err=%b want 1 %b", d, done_ok, done_err, !ack);
            end
        end
    endtask

    initial begin
        test_reset();
        test_led_cmd();
        test_parity();
        test_timeout();
        test_no_ack();
        test_reset_mid();
        test_busy_glitch();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got time limit want finish");
        $fatal(1, "watchdog");
    end

endmodule
